dma_axi_wr_burst: RTL

- Parametrised AXI4 write-channel DMA master. Takes a start address and a beat count, then splits the transfer into INCR bursts of at most MAX_BURST_LEN beats.
- No burst crosses a 4 KB boundary. Up to MAX_OUTSTANDING write responses may be pending at once.
- Sits between the DMA register block (cfg/status) and the system AXI interconnect. Write data arrives on a native valid/ready stream.

---
 rtl/dma_axi_pkg.sv | 23 ++
 rtl/dma_axi_burst_calc.sv | 32 +++
 rtl/dma_axi_wr_burst.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dma_axi_pkg.sv
// Shared types and AXI constants for the AXI4 write-burst DMA master.
package dma_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_RESP_W = 2;

  localparam int BOUNDARY_4K = 4096;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0010;
  localparam logic [2:0] AXI_PROT_DEF   = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_DRAIN
  } dma_state_e;

endpackage

// File: rtl/dma_axi_burst_calc.sv
// Burst sizing: min(remaining, MAX_BURST_LEN, beats left before the next 4 KB boundary).
module dma_axi_burst_calc
  import dma_axi_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MAX_BURST_LEN = 256,
  parameter int TRANS_W       = 16,
  localparam int CW           = (TRANS_W > 13) ? TRANS_W : 13
) (
  input  logic [11:0]          addr_lo,
  input  logic [TRANS_W-1:0]   remaining,
  output logic [CW-1:0]        burst,
  output logic [AXI_LEN_W-1:0] awlen
);

  localparam int SIZE_LOG2 = $clog2(DATA_W / 8);

  logic [12:0]   bytes_to_4k;
  logic [CW-1:0] beats_to_4k;
  logic [CW-1:0] b;

  always_comb begin
    bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, addr_lo};
    beats_to_4k = CW'(bytes_to_4k >> SIZE_LOG2);
    b = CW'(remaining);
    if (b > CW'(MAX_BURST_LEN)) b = CW'(MAX_BURST_LEN);
    if (b > beats_to_4k) b = beats_to_4k;
    burst = b;
    awlen = AXI_LEN_W'(b - CW'(1));
  end

endmodule

// File: rtl/dma_axi_wr_burst.sv
// AXI4 write-channel DMA master: splits a transfer into INCR bursts, tracks outstanding B responses.
// Optional DMA_AXI_WR_ERR_ABORT_EN: stop issuing AW after the first error response.
module dma_axi_wr_burst
  import dma_axi_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MAX_BURST_LEN   = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TRANS_W         = 16,
  localparam int STRB_W         = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AXI_ADDR_W-1:0] start_addr,
  input  logic [TRANS_W-1:0]    len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [STRB_W-1:0]     in_strb,
  output logic [AXI_ID_W-1:0]   m_axi_awid,
  output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
  output logic [AXI_LEN_W-1:0]  m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [STRB_W-1:0]     m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [AXI_RESP_W-1:0] m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  localparam int SIZE_LOG2 = $clog2(STRB_W);
  localparam int CW        = (TRANS_W > 13) ? TRANS_W : 13;

  dma_state_e             state, nstate;
  logic [AXI_ADDR_W-1:0]  addr_q;
  logic [TRANS_W-1:0]     remaining_q;
  logic [CW-1:0]          beat_cnt_q;
  logic [CW-1:0]          burst;
  logic [3:0]             outstanding_q;
  logic                   error_q, done_q;
  logic                   aw_allow, aw_hs, w_hs, last_beat, b_err, abort_hit;

  dma_axi_burst_calc #(
    .DATA_W        (DATA_W),
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .TRANS_W       (TRANS_W)
  ) u_calc (
    .addr_lo   (addr_q[11:0]),
    .remaining (remaining_q),
    .burst     (burst),
    .awlen     (m_axi_awlen)
  );

  assign aw_allow  = outstanding_q < 4'(MAX_OUTSTANDING);
  assign b_err     = m_axi_bvalid && (m_axi_bresp != AXI_RESP_OKAY);

  // AW fields come only from registers that hold still in ST_AW, so they stay stable until awready
  assign m_axi_awvalid = (state == ST_AW) && aw_allow;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awid    = '0;
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_MOD;
  assign m_axi_awprot  = AXI_PROT_DEF;
  assign m_axi_awqos   = '0;

  // W is a pure pass-through; in_ready depends only on wready and state, never on in_valid
  assign m_axi_wvalid = (state == ST_W) && in_valid;
  assign in_ready     = (state == ST_W) && m_axi_wready;
  assign m_axi_wdata  = in_data;
  assign m_axi_wstrb  = in_strb;
  assign m_axi_wlast  = (state == ST_W) && (beat_cnt_q == CW'(1));
  assign m_axi_bready = 1'b1;

  assign aw_hs     = m_axi_awvalid && m_axi_awready;
  assign w_hs      = m_axi_wvalid && m_axi_wready;
  assign last_beat = w_hs && m_axi_wlast;

`ifdef DMA_AXI_WR_ERR_ABORT_EN
  assign abort_hit = error_q || b_err;
`else
  assign abort_hit = 1'b0;
`endif

  assign busy  = (state != ST_IDLE);
  assign done  = done_q;
  assign error = error_q;

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (start && (len != '0)) nstate = ST_AW;
      ST_AW: begin
        if (aw_hs)                            nstate = ST_W;
        else if (abort_hit && !m_axi_awvalid) nstate = ST_DRAIN;
      end
      ST_W: begin
        if (last_beat)
          nstate = ((remaining_q == TRANS_W'(1)) || abort_hit) ? ST_DRAIN : ST_AW;
      end
      ST_DRAIN: if (outstanding_q == '0) nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      remaining_q   <= '0;
      beat_cnt_q    <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state  <= nstate;
      done_q <= (state == ST_DRAIN) && (outstanding_q == '0);

      if ((state == ST_IDLE) && start) begin
        error_q <= 1'b0;
        if (len == '0) done_q <= 1'b1;
        else           remaining_q <= len;
      end else if (busy && b_err) begin
        error_q <= 1'b1;
      end

      if (w_hs) remaining_q <= remaining_q - TRANS_W'(1);

      if (aw_hs)     beat_cnt_q <= burst;
      else if (w_hs) beat_cnt_q <= beat_cnt_q - CW'(1);

      case ({aw_hs, m_axi_bvalid && (outstanding_q != '0)})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  // Address datapath
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && start)
      addr_q <= start_addr & ~AXI_ADDR_W'(STRB_W - 1);
    else if (w_hs)
      addr_q <= addr_q + AXI_ADDR_W'(STRB_W);
  end

endmodule
